// File: rtl/alu_pkg.sv
// ALU sequencer shared definitions.
// Opcodes, FSM states and the registered flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle.
// prod_o is the accumulator after the current step; valid with done_o.
module alu_shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic [WIDTH:0]     sum;

  // Add multiplicand into the high half when the LSB is set, then shift.
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
        + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = acc_d;

  // Load on start, then step once per cycle until the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      mcand_q <= a_i;
      acc_q   <= {{WIDTH{1'b0}}, b_i};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one op in flight, valid/ready on both sides.
// Single-cycle ops go through EXEC, MUL runs the shift-add unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   res_q, res_d;
  flags_t             fl_q, fl_d;
  logic               accept;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_hi;

  logic [WIDTH:0]     add_w, sub_w;
  logic [SW-1:0]      sh;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_ill;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  assign result   = res_q;
  assign carry    = fl_q.carry;
  assign zero     = fl_q.zero;
  assign negative = fl_q.negative;
  assign overflow = fl_q.overflow;
  assign illegal  = fl_q.illegal;

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept && (opcode == OP_MUL)),
    .a_i     (A),
    .b_i     (B),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign mul_hi = |mul_prod[2*WIDTH-1:WIDTH];

  // Single-cycle datapath on the captured operands.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    sh      = b_q[SW-1:0];
    add_w   = {1'b0, a_q} + {1'b0, b_q};
    sub_w   = {1'b0, a_q} + {1'b0, ~b_q}
            + {{WIDTH{1'b0}}, 1'b1};
    case (op_q)
      OP_ADD: begin
        alu_res = add_w[M:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a_q[M] == b_q[M])
               && (add_w[M] != a_q[M]);
      end
      OP_SUB: begin
        alu_res = sub_w[M:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a_q[M] != b_q[M])
               && (sub_w[M] != a_q[M]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SLL: alu_res = a_q << sh;
      OP_SRL: alu_res = a_q >> sh;
      OP_SRA: alu_res = $unsigned($signed(a_q) >>> sh);
      default: alu_ill = 1'b1;
    endcase
  end

  // Next state and result/flag update.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    fl_d    = fl_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid)
          state_d = (opcode == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        res_d         = alu_res;
        fl_d.carry    = alu_c;
        fl_d.overflow = alu_v;
        fl_d.illegal  = alu_ill;
        fl_d.zero     = (alu_res == '0);
        fl_d.negative = alu_res[M];
        state_d       = S_DONE;
      end
      S_MUL: begin
        if (mul_done) begin
          res_d         = mul_prod[M:0];
          fl_d.carry    = mul_hi;
          fl_d.overflow = mul_hi;
          fl_d.illegal  = 1'b0;
          fl_d.zero     = (mul_prod[M:0] == '0);
          fl_d.negative = mul_prod[M];
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      fl_q    <= fl_d;
    end
  end

  // Operand capture on input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= opcode;
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits, SHALL be a power of two from 8 to 64.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port A  input  WIDTH  operand A, sampled on input handshake.
REQ-005 Port B  input  WIDTH  operand B (shift amount = B[log2(WIDTH)-1:0]), sampled on input handshake.
REQ-006 Port opcode  input  4  operation select, sampled on input handshake.
REQ-007 Port in_valid  input  1 / in_ready  output  1  input handshake; transfer when both high at a rising edge.
REQ-008 Port result  output  WIDTH  registered result.
REQ-009 Port carry, zero, negative, overflow  output  1 each  registered flags.
REQ-010 Port illegal  output  1  registered, high when the captured opcode is not in REQ-013.
REQ-011 Port out_valid  output  1 / out_ready  input  1  output handshake; transfer when both high at a rising edge.

Function
REQ-012 FSM states SHALL be IDLE, EXEC, MUL, DONE; only one operation in flight.
REQ-013 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SLL, 7 SRL, 8 SRA, 9 MUL (unsigned, low WIDTH bits); 10-15 illegal.
REQ-014 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE.
REQ-015 IDLE + in_valid: capture A, B, opcode; go MUL if opcode=9, else EXEC.
REQ-016 EXEC: compute, register result/flags, go DONE; out_valid rises 2 cycles after acceptance edge.
REQ-017 MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then register result/flags, go DONE; out_valid rises WIDTH+1 cycles after acceptance edge.
REQ-018 DONE: result/flags held stable; go IDLE on out_ready; no new operation accepted in the same cycle.
REQ-019 ADD: carry = carry-out of A+B; overflow = signed overflow.
REQ-020 SUB: computed as A+~B+1; carry = its carry-out (1 = no borrow); overflow = signed overflow.
REQ-021 AND/OR/XOR/NOT/shifts: carry=0, overflow=0; SRA replicates A[WIDTH-1]; shift amount 0 returns A.
REQ-022 MUL: carry = overflow = 1 iff upper WIDTH bits of full 2*WIDTH product nonzero.
REQ-023 Every op: zero = (result==0), negative = result[WIDTH-1].
REQ-024 Illegal opcode: path via EXEC, result=0, zero=1, other flags 0, illegal=1; illegal=0 for legal ops.
REQ-025 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-026 rst high SHALL force IDLE immediately, including mid-MUL or in DONE; in-flight op discarded.
REQ-027 Reset values: result=0, carry=0, zero=0, negative=0, overflow=0, illegal=0, out_valid=0, in_ready=1 (after deassertion, IDLE).
REQ-028 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-029 Package alu_pkg SHALL hold the opcode constants and FSM state encoding; shared with benches.
REQ-030 Multiplier SHALL be sub-module alu_shift_add_mul (start/done, WIDTH-parametrised); remaining logic inline in alu_seq.

Verification (WIDTH=32 unless stated)
REQ-031 ADD 0x7FFFFFFF+1 -> result 0x80000000, overflow=1, negative=1, carry=0, out_valid 2 cycles after accept.
REQ-032 SUB 5-5 -> result 0, zero=1, carry=1; SUB 0-1 -> 0xFFFFFFFF, carry=0, negative=1.
REQ-033 MUL 0x10000*0x10000 -> result 0, carry=overflow=1, zero=1, out_valid exactly 33 cycles after accept; MUL 255*255 -> 0xFE01, flags 0.
REQ-034 SRA 0x80000000 by B=4 -> 0xF8000000; SLL 1 by B=35 -> 8 (amount = B[4:0]).
REQ-035 out_ready held low 10 cycles in DONE -> result stable, in_ready=0, in_valid ignored; opcode 12 -> illegal=1, result 0, zero=1.
REQ-036 rst pulsed mid-MUL (cycle 10) -> out_valid=0, all outputs reset, next ADD 2+3 -> 5; repeat ADD/SUB/MUL checks at WIDTH=8.
